sos_detector: RTL and testbench
===============================

Name: sos_detector

Overview:
- Receiver stage directly downstream of the Morse SOS driver; consumes its serial on/off line on the same clock.
- Measures mark (high) and space (low) run lengths and classifies each mark as dot or dash.
- Keeps a 9-symbol history and pulses a flag when the history matches S-O-S (dot dot dot, dash dash dash, dot dot dot).

Parameters:
- CNT_W, 5: width of the run-length counters; counters saturate at 2^CNT_W-1.
- DOT_MIN, 1: minimum mark length in cycles classified as a dot.
- DOT_MAX, 2: maximum mark length in cycles classified as a dot.
- DASH_MIN, 3: minimum mark length in cycles classified as a dash.
- DASH_MAX, 5: maximum mark length in cycles classified as a dash.
- GAP_MAX, 8: longest space in cycles that keeps the symbol history alive.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- dataIn  in  1  serial Morse line, synchronous to clk, 1 = mark.
- symValid  out  1  one-cycle pulse when a mark has just ended and been classified as a legal symbol.
- symDash  out  1  symbol type, valid while symValid is high: 0 = dot, 1 = dash.
- errPulse  out  1  one-cycle pulse when an ended mark falls outside both the dot and the dash window.
- sosFound  out  1  one-cycle pulse when the full SOS pattern is detected.

Behaviour:
- Reset:
  - Interface: one clock; reset is asynchronous and active-high.
  - All outputs go to 0; FSM enters IDLE; counters and history clear; prev-sample register clears to 0.
  - Reset asserted mid-sequence discards any partial history with no pulse.
- Sampling:
  - dataIn is sampled once per rising edge; there is no synchroniser.
  - Mark length L = number of consecutive edges at which dataIn is sampled 1.
- FSM states: IDLE, MARK, SPACE.
  - IDLE: on dataIn=1, go to MARK with markCnt=1.
  - MARK: increment markCnt (saturating) while dataIn=1.
  - MARK: on the first edge sampling dataIn=0, classify, go to SPACE, set spaceCnt=1.
  - SPACE: increment spaceCnt (saturating) while dataIn=0.
  - SPACE: on dataIn=1, go to MARK with markCnt=1.
  - SPACE: when spaceCnt reaches GAP_MAX+1, clear history and count, go to IDLE. No pulse is raised.
- Classification (at the edge the mark ends):
  - DOT_MIN<=L<=DOT_MAX gives a dot.
  - DASH_MIN<=L<=DASH_MAX gives a dash.
  - Any other L, including a saturated counter, is an error: errPulse=1, history and count cleared, no symValid.
- Output timing:
  - symValid, symDash, errPulse and sosFound are registered.
  - They are high for exactly the one cycle following the classifying edge, giving a latency of 1 cycle after the first low sample.
- History:
  - 9-bit shift register; each new symbol shifts in at bit 0 (1 = dash).
  - symCount saturates at 9.
- Match:
  - sosFound=1 in the same cycle as the symValid of the symbol that makes symCount>=9 and history==9'b000111000.
  - On a match, history and count clear (non-overlapping detection); a new SOS needs 9 fresh symbols.
- Boundaries:
  - A mark that starts on the same edge the gap timeout fires: the timeout clear happens first, then the mark starts from an empty history.
  - A mark held high forever never classifies until it falls; it then reports errPulse.
  - Parameters must satisfy DOT_MAX<DASH_MIN and DASH_MAX<2^CNT_W-1; check with an elaboration-time assertion.

Optional Feature:
- SOS_COUNT_EN defined:
  - Adds output port sosCount [7:0], a running count of sosFound pulses.
  - It saturates at 255 and is cleared only by rst.
  - It updates in the same cycle sosFound is high.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package sos_pkg holds:
  - SYM_DOT=1'b0, SYM_DASH=1'b1.
  - SOS_LEN=9 and SOS_PATTERN=9'b000111000.
  - The FSM state encoding (IDLE, MARK, SPACE).
- One natural sub-module, sos_pulse_classifier:
  - Contents: FSM, mark/space counters and dot/dash/error classification.
  - Outputs: sym strobe, type, error strobe and timeout strobe.
- The top level keeps the history register, the pattern compare and the optional counter.

Test Plan:
- Driver-style stream, marks 1,1,1,3,3,3,1,1,1 with 1-cycle spaces -> eight symValid pulses, then a ninth with sosFound=1 in the same cycle; symDash sequence 0,0,0,1,1,1,0,0,0.
- Same stream with dash marks of 4 and 5 cycles and dots of 2 -> still detected; a mark of 6 cycles in the second letter -> errPulse=1, no symValid, and no sosFound for that sequence.
- Valid 5 symbols, then a space of 9 cycles, then the remaining 4 symbols -> no sosFound; after the timeout a full SOS -> sosFound.
- Two back-to-back SOS sequences -> exactly two sosFound pulses; a sequence sharing symbols across the boundary, e.g. SOSOS, yields a single pulse.
- rst pulsed asynchronously after symbol 6 -> outputs 0 at once; the remaining 3 symbols produce no sosFound; a following full SOS detects.
- With SOS_COUNT_EN: 3 detections -> sosCount=3; force 260 detections -> sosCount holds at 255.

Source files
------------

// File: rtl/sos_pkg.sv
// Shared symbol encodings, SOS pattern and classifier FSM states for the SOS receiver.
package sos_pkg;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  localparam int SOS_LEN   = 9;
  localparam int SOS_CNT_W = $clog2(SOS_LEN + 1);

  localparam logic [SOS_LEN-1:0] SOS_PATTERN = 9'b000111000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  // Symbol counter only needs to know "at least SOS_LEN seen".
  function automatic logic [SOS_CNT_W-1:0] sym_count_inc(input logic [SOS_CNT_W-1:0] c);
    logic [SOS_CNT_W-1:0] len_c;
    len_c = SOS_CNT_W'(SOS_LEN);
    return (c >= len_c) ? len_c : c + 1'b1;
  endfunction

endpackage

// File: rtl/sos_pulse_classifier.sv
// Run-length FSM for the serial Morse line: measures marks/spaces and emits combinational
// strobes for dot/dash symbols, out-of-window marks and inter-symbol gap timeouts.
module sos_pulse_classifier
  import sos_pkg::*;
#(
  parameter int CNT_W    = 5,
  parameter int DOT_MIN  = 1,
  parameter int DOT_MAX  = 2,
  parameter int DASH_MIN = 3,
  parameter int DASH_MAX = 5,
  parameter int GAP_MAX  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic dataIn,
  output logic sym_stb,
  output logic sym_type,
  output logic err_stb,
  output logic timeout_stb
);

  generate
    if (!(DOT_MIN >= 1 && DOT_MIN <= DOT_MAX && DOT_MAX < DASH_MIN &&
          DASH_MIN <= DASH_MAX && DASH_MAX < (2**CNT_W) - 1 &&
          GAP_MAX >= 1 && GAP_MAX + 1 <= (2**CNT_W) - 1)) begin : g_param_check
      $error("sos_pulse_classifier: illegal dot/dash/gap window parameters");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_MAX + 1);
  localparam logic [CNT_W-1:0] DOT_LO   = CNT_W'(DOT_MIN);
  localparam logic [CNT_W-1:0] DOT_HI   = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] DASH_LO  = CNT_W'(DASH_MIN);
  localparam logic [CNT_W-1:0] DASH_HI  = CNT_W'(DASH_MAX);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] mark_cnt_reg, mark_cnt_next;
  logic [CNT_W-1:0] space_cnt_reg, space_cnt_next;
  logic             is_dot, is_dash;

  // A saturated counter lands above DASH_MAX and therefore falls into the error case.
  assign is_dot  = (mark_cnt_reg >= DOT_LO)  && (mark_cnt_reg <= DOT_HI);
  assign is_dash = (mark_cnt_reg >= DASH_LO) && (mark_cnt_reg <= DASH_HI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      mark_cnt_reg  <= '0;
      space_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      mark_cnt_reg  <= mark_cnt_next;
      space_cnt_reg <= space_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    mark_cnt_next  = mark_cnt_reg;
    space_cnt_next = space_cnt_reg;
    sym_stb        = 1'b0;
    sym_type       = SYM_DOT;
    err_stb        = 1'b0;
    timeout_stb    = 1'b0;

    case (state_reg)
      IDLE: begin
        space_cnt_next = '0;
        if (dataIn) begin
          state_next    = MARK;
          mark_cnt_next = CNT_ONE;
        end
      end

      MARK: begin
        if (dataIn) begin
          if (mark_cnt_reg != CNT_MAX) begin
            mark_cnt_next = mark_cnt_reg + 1'b1;
          end
        end else begin
          if (is_dot) begin
            sym_stb  = 1'b1;
            sym_type = SYM_DOT;
          end else if (is_dash) begin
            sym_stb  = 1'b1;
            sym_type = SYM_DASH;
          end else begin
            err_stb = 1'b1;
          end
          state_next     = SPACE;
          mark_cnt_next  = '0;
          space_cnt_next = CNT_ONE;
        end
      end

      SPACE: begin
        // The timeout clear is taken first even if a new mark begins on this edge.
        if (space_cnt_reg == GAP_END) begin
          timeout_stb    = 1'b1;
          space_cnt_next = '0;
          if (dataIn) begin
            state_next    = MARK;
            mark_cnt_next = CNT_ONE;
          end else begin
            state_next = IDLE;
          end
        end else if (dataIn) begin
          state_next     = MARK;
          mark_cnt_next  = CNT_ONE;
          space_cnt_next = '0;
        end else if (space_cnt_reg != CNT_MAX) begin
          space_cnt_next = space_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next     = IDLE;
        mark_cnt_next  = '0;
        space_cnt_next = '0;
      end
    endcase
  end

endmodule

// File: rtl/sos_detector.sv
// Morse SOS receiver: keeps a 9-symbol history and pulses sosFound on a non-overlapping match.
// Optional feature: define SOS_COUNT_EN to add the saturating sosCount[7:0] output.
module sos_detector
  import sos_pkg::*;
#(
  parameter int CNT_W    = 5,
  parameter int DOT_MIN  = 1,
  parameter int DOT_MAX  = 2,
  parameter int DASH_MIN = 3,
  parameter int DASH_MAX = 5,
  parameter int GAP_MAX  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dataIn,
  output logic       symValid,
  output logic       symDash,
  output logic       errPulse,
`ifdef SOS_COUNT_EN
  output logic       sosFound,
  output logic [7:0] sosCount
`else
  output logic       sosFound
`endif
);

  logic sym_stb, sym_type, err_stb, timeout_stb;

  sos_pulse_classifier #(
    .CNT_W    (CNT_W),
    .DOT_MIN  (DOT_MIN),
    .DOT_MAX  (DOT_MAX),
    .DASH_MIN (DASH_MIN),
    .DASH_MAX (DASH_MAX),
    .GAP_MAX  (GAP_MAX)
  ) u_classifier (
    .clk         (clk),
    .rst         (rst),
    .dataIn      (dataIn),
    .sym_stb     (sym_stb),
    .sym_type    (sym_type),
    .err_stb     (err_stb),
    .timeout_stb (timeout_stb)
  );

  logic [SOS_LEN-1:0]   history_reg, history_next, history_shift;
  logic [SOS_CNT_W-1:0] count_reg, count_next, count_inc;
  logic                 match;

  always_comb begin
    history_shift = {history_reg[SOS_LEN-2:0], sym_type};
    count_inc     = sym_count_inc(count_reg);
    match         = sym_stb && (count_inc >= SOS_CNT_W'(SOS_LEN)) &&
                    (history_shift == SOS_PATTERN);

    history_next = history_reg;
    count_next   = count_reg;
    // A match clears too, so a following SOS needs nine fresh symbols.
    if (timeout_stb || err_stb || match) begin
      history_next = '0;
      count_next   = '0;
    end else if (sym_stb) begin
      history_next = history_shift;
      count_next   = count_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history_reg <= '0;
      count_reg   <= '0;
      symValid    <= 1'b0;
      symDash     <= 1'b0;
      errPulse    <= 1'b0;
      sosFound    <= 1'b0;
    end else begin
      history_reg <= history_next;
      count_reg   <= count_next;
      symValid    <= sym_stb;
      symDash     <= sym_stb & sym_type;
      errPulse    <= err_stb;
      sosFound    <= match;
    end
  end

`ifdef SOS_COUNT_EN
  logic [7:0] sos_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sos_count_reg <= '0;
    end else if (match && (sos_count_reg != 8'hFF)) begin
      sos_count_reg <= sos_count_reg + 8'd1;
    end
  end

  assign sosCount = sos_count_reg;
`endif

endmodule

// File: tb/tb_sos_detector.sv
// Directed bench for sos_detector: hand-computed symbol/error/SOS expectations per mark.
module tb_sos_detector;

  logic       clk;
  logic       rst;
  logic       dataIn;
  logic       symValid, symDash, errPulse, sosFound;
`ifdef SOS_COUNT_EN
  logic [7:0] sosCount;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int sos_seen = 0;
  int err_seen = 0;
  bit quiet = 1'b0;
  int base;

  sos_detector dut (
    .clk      (clk),
    .rst      (rst),
    .dataIn   (dataIn),
    .symValid (symValid),
    .symDash  (symDash),
    .errPulse (errPulse),
`ifdef SOS_COUNT_EN
    .sosFound (sosFound),
    .sosCount (sosCount)
`else
    .sosFound (sosFound)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses are one cycle wide, so each is seen at exactly one rising edge.
  always @(posedge clk) begin
    if (sosFound === 1'b1) sos_seen++;
    if (errPulse === 1'b1) err_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("[TB] check %-14s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic drive(input logic v);
    dataIn = v;
    @(negedge clk);
  endtask

  // Mark of len cycles followed by one low sample; outputs are checked the cycle after it.
  task automatic sym(input int len, input logic ev, input logic ed, input logic ee, input logic es);
    repeat (len) drive(1'b1);
    drive(1'b0);
    if (!quiet) begin
      chk("symValid", 32'(symValid), 32'(ev));
      chk("symDash",  32'(symDash),  32'(ed));
      chk("errPulse", 32'(errPulse), 32'(ee));
      chk("sosFound", 32'(sosFound), 32'(es));
    end
  endtask

  task automatic gap(input int n);
    repeat (n) drive(1'b0);
  endtask

  task automatic letter_s(input int d, input logic last_sos);
    sym(d, 1, 0, 0, 0);
    sym(d, 1, 0, 0, 0);
    sym(d, 1, 0, 0, last_sos);
  endtask

  task automatic letter_o(input int a, input int b, input int c);
    sym(a, 1, 1, 0, 0);
    sym(b, 1, 1, 0, 0);
    sym(c, 1, 1, 0, 0);
  endtask

  task automatic full_sos(input int d, input logic exp_sos);
    letter_s(d, 1'b0);
    letter_o(3, 3, 3);
    letter_s(d, exp_sos);
  endtask

  task automatic clean_gap();
    gap(12);
  endtask

  initial begin
    rst    = 1'b1;
    dataIn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_symValid", 32'(symValid), 32'd0);
    chk("rst_symDash",  32'(symDash),  32'd0);
    chk("rst_errPulse", 32'(errPulse), 32'd0);
    chk("rst_sosFound", 32'(sosFound), 32'd0);
`ifdef SOS_COUNT_EN
    chk("rst_sosCount", 32'(sosCount), 32'd0);
`endif
    rst = 1'b0;
    gap(2);

    // Driver-style stream: 1/3-cycle marks with single-cycle spaces.
    full_sos(1, 1'b1);
    gap(2);
    chk("sos_count_a", 32'(sos_seen), 32'd1);

    // Dots of 2, dashes of 4 and 5.
    clean_gap();
    letter_s(2, 1'b0);
    letter_o(4, 5, 4);
    letter_s(2, 1'b1);
    gap(2);
    chk("sos_count_b", 32'(sos_seen), 32'd2);

    // A 6-cycle mark inside the O kills the sequence.
    clean_gap();
    base = err_seen;
    letter_s(2, 1'b0);
    sym(4, 1, 1, 0, 0);
    sym(6, 0, 0, 1, 0);
    sym(5, 1, 1, 0, 0);
    letter_s(2, 1'b0);
    gap(2);
    chk("err_count", 32'(err_seen - base), 32'd1);
    chk("sos_count_c", 32'(sos_seen), 32'd2);

    // A mark held high far past saturation still ends in an error.
    sym(40, 0, 0, 1, 0);

    // Space of 8 keeps history alive.
    clean_gap();
    letter_s(1, 1'b0);
    sym(3, 1, 1, 0, 0);
    sym(3, 1, 1, 0, 0);
    gap(7);
    sym(3, 1, 1, 0, 0);
    letter_s(1, 1'b1);
    gap(2);
    chk("sos_count_d", 32'(sos_seen), 32'd3);

    // Space of 9 times out exactly as the next mark starts; sequence is lost.
    clean_gap();
    letter_s(1, 1'b0);
    sym(3, 1, 1, 0, 0);
    sym(3, 1, 1, 0, 0);
    gap(8);
    sym(3, 1, 1, 0, 0);
    letter_s(1, 1'b0);
    gap(2);
    chk("sos_count_e", 32'(sos_seen), 32'd3);
    clean_gap();
    full_sos(1, 1'b1);
    gap(2);
    chk("sos_count_f", 32'(sos_seen), 32'd4);

    // Back-to-back SOS: two pulses.
    clean_gap();
    full_sos(1, 1'b1);
    full_sos(1, 1'b1);
    gap(2);
    chk("sos_count_g", 32'(sos_seen), 32'd6);

    // SOSOS: non-overlapping, only one pulse.
    clean_gap();
    full_sos(1, 1'b1);
    letter_o(3, 3, 3);
    letter_s(1, 1'b0);
    gap(2);
    chk("sos_count_h", 32'(sos_seen), 32'd7);

    // Async reset after symbol 6 while symValid is high.
    clean_gap();
    letter_s(1, 1'b0);
    letter_o(3, 3, 3);
    #1 rst = 1'b1;
    #1;
    chk("arst_symValid", 32'(symValid), 32'd0);
    chk("arst_symDash",  32'(symDash),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    letter_s(1, 1'b0);
    full_sos(1, 1'b1);
    gap(2);
    chk("sos_count_i", 32'(sos_seen), 32'd8);

`ifdef SOS_COUNT_EN
    clean_gap();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("cnt_cleared", 32'(sosCount), 32'd0);
    repeat (3) full_sos(1, 1'b1);
    gap(2);
    chk("cnt_three", 32'(sosCount), 32'd3);
    quiet = 1'b1;
    repeat (257) full_sos(1, 1'b1);
    quiet = 1'b0;
    gap(2);
    chk("cnt_saturate", 32'(sosCount), 32'd255);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
